prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 30'h0: word address of the first loaded word.
REQ-002 Parameter TIMEOUT, default 1000000: maximum idle cycles between accepted bytes during a load.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_byte is valid in this cycle.
REQ-006 rx_byte  input  8  received serial byte.
REQ-007 rx_ready  output  1  loader can accept a byte this cycle.
REQ-008 mem_ready  input  1  memory accepts the write presented this cycle.
REQ-009 mem_addr  output  30  word address of the write.
REQ-010 mem_data  output  32  write data.
REQ-011 mem_wren  output  1  write request; held until mem_ready is high.
REQ-012 core_rst  output  1  holds the pipeline in reset; high in every state except DONE.
REQ-013 busy  output  1  high in states CNT_HI, CNT_LO, DATA, CHECK.
REQ-014 done  output  1  high in state DONE.
REQ-015 error  output  1  high in state ERR.

Function
REQ-016 The frame SHALL be: header 0xA5, word count N (16-bit, high byte first), 4*N data bytes (each word big-endian), then an optional checksum byte (REQ-034).
REQ-017 The states SHALL be IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE and ERR.
REQ-018 A byte SHALL be accepted only when rx_valid and rx_ready are both high.
REQ-019 In IDLE, DONE or ERR, accepting 0xA5 SHALL move to CNT_HI, clear the word index, and clear the checksum; any other byte SHALL be ignored.
REQ-020 CNT_HI SHALL latch the count high byte and move to CNT_LO.
REQ-021 CNT_LO SHALL latch the count low byte; if N=0, move to CHECK when enabled, else to DONE; otherwise move to DATA.
REQ-022 DATA SHALL shift each accepted byte into a 32-bit assembly register (first byte ends up in bits 31:24).
REQ-023 The cycle after the 4th byte of a word is accepted, mem_wren SHALL go high, with mem_addr = BASE_ADDR + index (modulo 2^30) and mem_data = the assembled word.
REQ-024 mem_wren, mem_addr and mem_data SHALL stay stable while mem_ready is low; the write completes in the first cycle with mem_wren and mem_ready both high.
REQ-025 On write completion, index SHALL increment; once index reaches N, the state SHALL move to CHECK when enabled, else to DONE.
REQ-026 rx_ready SHALL be low while a write is pending, and high otherwise in every state.
REQ-027 rx_valid arriving while rx_ready is low SHALL move to ERR (overrun); the byte is discarded.
REQ-028 In CNT_HI, CNT_LO, DATA and CHECK, an idle counter SHALL clear on each accepted byte and increment otherwise.
REQ-029 When the idle counter reaches TIMEOUT, the state SHALL move to ERR.
REQ-030 Entering ERR SHALL deassert mem_wren immediately; any partial word is discarded.
REQ-031 mem_wren SHALL never be high outside DATA.

Reset
REQ-032 While rst is high: state=IDLE; index, count, idle counter and checksum=0; mem_wren=0; mem_addr=0; mem_data=0; core_rst=1; busy=0; done=0; error=0; rx_ready=1.
REQ-033 Reset asserted mid-load SHALL abort the load with no further writes; words already written remain in memory.

Configuration
REQ-034 With LOADER_CHECKSUM_EN defined: the running XOR of all data bytes is kept; CHECK accepts one byte; a match moves to DONE, a mismatch moves to ERR.
REQ-035 Without LOADER_CHECKSUM_EN: CHECK and the checksum register are not built, and the last write completion moves directly to DONE.

Verification
REQ-036 Frame A5 00 01 DE AD BE EF (checksum 22 when enabled), mem_ready=1 -> one write: addr=BASE_ADDR, data=32'hDEADBEEF; then done=1, core_rst=0.
REQ-037 Two-word frame with mem_ready low for 5 cycles on the first write -> mem_wren held 5 cycles with stable addr/data; rx_ready=0 throughout; second write to BASE_ADDR+1.
REQ-038 Byte strobed while a write is pending -> error=1, core_rst=1, no further writes; a following A5 restarts the load.
REQ-039 TIMEOUT=16, frame stopped after A5 00 -> error=1 at the 16th idle cycle.
REQ-040 With LOADER_CHECKSUM_EN, frame A5 00 01 01 02 03 04 checksum 05 -> ERR (expected 04); with 04 -> DONE.
REQ-041 Frame A5 00 00 -> no writes; then DONE (or CHECK expecting 00); rst pulse during DATA -> IDLE, core_rst=1.

Source files
------------

// File: rtl/prog_loader.sv
// Serial program loader: parses an A5 / count / big-endian data frame and writes words to memory.
// Optional trailing XOR checksum byte is built when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter logic [29:0] BASE_ADDR = 30'h0,
    parameter int          TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    input  logic        mem_ready,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CNT_HI, ST_CNT_LO, ST_DATA, ST_CHECK, ST_DONE, ST_ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_FINISH = ST_CHECK;
`else
    localparam state_t ST_FINISH = ST_DONE;
`endif

    state_t              state;
    state_t              state_next;
    logic [15:0]         count;
    logic [15:0]         index;
    logic [1:0]          byte_cnt;
    logic [23:0]         shift_reg;
    logic [IDLE_W-1:0]   idle_cnt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          checksum;
`endif

    logic accept;
    logic overrun;
    logic wr_done;
    logic in_load;
    logic timed_out;
    logic last_word;
    logic restartable;

    // rx_ready is simply "no write pending", so an overrun can only occur in DATA.
    assign accept      = rx_valid && rx_ready;
    assign overrun     = rx_valid && !rx_ready;
    assign wr_done     = mem_wren && mem_ready;
    assign in_load     = (state == ST_CNT_HI) || (state == ST_CNT_LO) ||
                         (state == ST_DATA)   || (state == ST_CHECK);
    assign timed_out   = in_load && !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign last_word   = (index + 16'd1) == count;
    assign restartable = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (overrun || timed_out) begin
            state_next = ST_ERR;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (accept && rx_byte == 8'hA5) state_next = ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    if (accept) state_next = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    if (accept) begin
                        state_next = ({count[15:8], rx_byte} == 16'd0) ? ST_FINISH : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (wr_done && last_word) state_next = ST_FINISH;
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) state_next = (rx_byte == checksum) ? ST_DONE : ST_ERR;
                end
`endif
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_ready = !mem_wren;
        core_rst = (state != ST_DONE);
        busy     = in_load;
        done     = (state == ST_DONE);
        error    = (state == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            index     <= '0;
            byte_cnt  <= '0;
            shift_reg <= '0;
            idle_cnt  <= '0;
            mem_wren  <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            if (in_load && !accept) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end else begin
                idle_cnt <= '0;
            end

            if (accept && restartable && rx_byte == 8'hA5) begin
                index    <= '0;
                byte_cnt <= '0;
                count    <= '0;
`ifdef LOADER_CHECKSUM_EN
                checksum <= '0;
`endif
            end

            if (accept && state == ST_CNT_HI) count[15:8] <= rx_byte;
            if (accept && state == ST_CNT_LO) count[7:0]  <= rx_byte;

            // Only the first three bytes are held; the fourth goes straight into mem_data.
            if (accept && state == ST_DATA) begin
                shift_reg <= {shift_reg[15:0], rx_byte};
                byte_cnt  <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                checksum  <= checksum ^ rx_byte;
`endif
                if (byte_cnt == 2'd3) begin
                    mem_wren <= 1'b1;
                    mem_addr <= BASE_ADDR + 30'(index);
                    mem_data <= {shift_reg, rx_byte};
                end
            end

            if (wr_done) begin
                mem_wren <= 1'b0;
                index    <= index + 16'd1;
            end

            // Leaving DATA for any reason (finish, overrun, timeout) drops the request.
            if (state_next != ST_DATA) mem_wren <= 1'b0;
        end
    end

endmodule
